mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline. Consumes the EX/MEM register outputs (*_m signals) and performs loads and stores on a private word-addressed data memory with a configurable access latency.
- Stalls upstream while an access is in flight.
- Contains the MEM/WB register and drives the *_w signals to the writeback stage.

Parameters:
- MEM_WORDS, 256, data memory depth in 32-bit words; power of two; ADDR_W = clog2(MEM_WORDS).
- ACCESS_LATENCY, 2, cycles a load/store occupies the stage; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- reg_write_m  in  1  instruction writes the register file
- mem_to_reg_m  in  1  load: writeback data comes from memory
- mem_write_m  in  1  store
- alu_result_m  in  32  byte address for memory ops; result for non-memory ops
- write_data_m  in  32  store data
- write_reg_m  in  5  destination register
- stall_m  out  1  upstream must hold all *_m inputs and the EX/MEM register stable
- reg_write_w  out  1  registered
- mem_to_reg_w  out  1  registered
- read_data_w  out  32  registered load data
- alu_result_w  out  32  registered
- write_reg_w  out  5  registered
- misaligned_w  out  1  registered; the retiring memory op had alu_result_m[1:0] != 0

Behaviour:
- Memory op: mem_to_reg_m or mem_write_m is 1. Word index = alu_result_m[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
- Internal state: FSM IDLE/BUSY plus a counter cnt (width clog2(16)+1). Reset: state IDLE, cnt 0, all *_w outputs 0.
- Memory contents are not cleared by reset.
- stall_m is combinational. It is 0 while reset is 1.
- Non-memory op, or memory op with ACCESS_LATENCY=1: no stall. The op retires at the next edge, loading *_w from *_m.
  - read_data_w = memory word for a load, 0 otherwise.
- Memory op with ACCESS_LATENCY>1, IDLE: stall_m=1. At the edge: go BUSY, cnt=1. *_w loads a bubble: reg_write_w=0, mem_to_reg_w=0, misaligned_w=0, other *_w hold their values.
- BUSY: stall_m = (cnt != ACCESS_LATENCY-1).
  - At an edge with cnt < ACCESS_LATENCY-1: cnt++, and *_w loads the bubble.
  - At an edge with cnt == ACCESS_LATENCY-1: perform the access, load *_w, return to IDLE, cnt=0.
- Each op therefore occupies exactly ACCESS_LATENCY cycles, with stall_m high for the first ACCESS_LATENCY-1 of them. Exactly one non-bubble *_w result is produced per op.
- Store: memory write at the retiring edge only.
- Load: read at the retiring edge; read-before-write semantics.
- mem_write_m and mem_to_reg_m both 1: the store is performed, read_data_w = the pre-store word, mem_to_reg_w=1.
- Misaligned memory op:
  - The store is suppressed.
  - A load returns read_data_w=0.
  - misaligned_w=1 for that retiring op.
  - Latency is unchanged.
- Back-to-back memory ops: the IDLE entered on retire may immediately accept the next op; there are no dead cycles beyond the latency.
- *_m inputs are sampled only at the retiring edge. Changes while stall_m=1 are a protocol violation; behaviour is undefined and checked by a bench assertion.
- Reset asserted mid-op: the op is aborted and no memory write occurs. Next cycle: IDLE, *_w all 0, stall_m=0.

Test Plan:
- ACCESS_LATENCY=2, non-memory op reg_write_m=1, alu_result_m=0x00001234, write_reg_m=5 -> stall_m=0; next cycle reg_write_w=1, alu_result_w=0x1234, write_reg_w=5.
- ACCESS_LATENCY=2, store 0xDEADBEEF at 0x10, then load 0x10 to reg 8 ->
  - stall_m=1 for one cycle per op.
  - Load retires with read_data_w=0xDEADBEEF, mem_to_reg_w=1, write_reg_w=8.
- ACCESS_LATENCY=4, load -> stall_m high 3 consecutive cycles; reg_write_w=0 during them; exactly one cycle with reg_write_w=1 afterwards.
- Word 0x10 holds 0x11111111; misaligned store 0x22222222 at 0x13 -> misaligned_w=1; subsequent load 0x10 returns 0x11111111.
- ACCESS_LATENCY=4, store 0xCAFEF00D at 0x20 with reset pulsed during BUSY (cnt=2) ->
  - No write; all *_w=0; stall_m=0 the cycle after reset.
  - Later load 0x20 returns the prior contents.
- MEM_WORDS=256, store 0xA5A5A5A5 at 0x400 -> load 0x000 returns 0xA5A5A5A5 (wrap).

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: private word-addressed data memory with fixed access latency,
// upstream stall while an access is in flight, and the MEM/WB register.
//
// state | meaning
// IDLE  | ready; non-memory ops (or any op when latency is 1) retire at the next edge
// BUSY  | memory op in flight; r_cnt counts occupied cycles, retires at ACCESS_LATENCY-1
module mem_stage #(
    parameter int MEM_WORDS      = 256,
    parameter int ACCESS_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write_m,
    input  logic        mem_to_reg_m,
    input  logic        mem_write_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic [4:0]  write_reg_m,
    output logic        stall_m,
    output logic        reg_write_w,
    output logic        mem_to_reg_w,
    output logic [31:0] read_data_w,
    output logic [31:0] alu_result_w,
    output logic [4:0]  write_reg_w,
    output logic        misaligned_w
);
    localparam int ADDR_W = $clog2(MEM_WORDS);
    localparam int CNT_W  = $clog2(16) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_LATENCY - 1);
    localparam bit MULTI_CYCLE = (ACCESS_LATENCY > 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_mem [MEM_WORDS];

    logic               w_mem_op;
    logic               w_misaligned;
    logic               w_retire;
    logic [ADDR_W-1:0]  w_idx;
    logic [31:0]        w_rdata;

    assign w_mem_op     = mem_to_reg_m | mem_write_m;
    assign w_misaligned = (alu_result_m[1:0] != 2'b00);
    assign w_idx        = alu_result_m[ADDR_W+1:2];
    assign w_rdata      = r_mem[w_idx];

    always_comb begin
        w_retire = 1'b0;
        stall_m  = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op && MULTI_CYCLE) stall_m  = 1'b1;
                    else                         w_retire = 1'b1;
                end
                BUSY: begin
                    if (r_cnt == LAST_CNT) w_retire = 1'b1;
                    else                   stall_m  = 1'b1;
                end
                default: w_retire = 1'b0;
            endcase
        end
    end

    // Memory is not reset; a write happens only on the retiring edge of an aligned store.
    always_ff @(posedge clk) begin
        if (!reset && w_retire && mem_write_m && !w_misaligned)
            r_mem[w_idx] <= write_data_m;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            read_data_w  <= '0;
            alu_result_w <= '0;
            write_reg_w  <= '0;
            misaligned_w <= 1'b0;
        end else if (w_retire) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
            read_data_w  <= (mem_to_reg_m && !w_misaligned) ? w_rdata : 32'h0;
            alu_result_w <= alu_result_m;
            write_reg_w  <= write_reg_m;
            misaligned_w <= w_mem_op & w_misaligned;
        end else begin
            // Bubble: only the control bits clear, data fields hold.
            r_state      <= BUSY;
            r_cnt        <= r_cnt + CNT_W'(1);
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            misaligned_w <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (latency 1, 2, 4) driven by per-op tasks,
// with expected writeback results queued at issue and compared at retire.
module tb_mem_stage;
    typedef struct {
        logic        rw;
        logic        mtr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [3];
    logic        reg_write_m  [3];
    logic        mem_to_reg_m [3];
    logic        mem_write_m  [3];
    logic [31:0] alu_result_m [3];
    logic [31:0] write_data_m [3];
    logic [4:0]  write_reg_m  [3];
    logic        stall_m      [3];
    logic        reg_write_w  [3];
    logic        mem_to_reg_w [3];
    logic [31:0] read_data_w  [3];
    logic [31:0] alu_result_w [3];
    logic [4:0]  write_reg_w  [3];
    logic        misaligned_w [3];

    logic [31:0] model [3][256];
    exp_t        sbq[$];
    int          compared = 0;
    int          mismatched = 0;

    mem_stage #(.MEM_WORDS(256), .ACCESS_LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst[0]), .reg_write_m(reg_write_m[0]), .mem_to_reg_m(mem_to_reg_m[0]),
        .mem_write_m(mem_write_m[0]), .alu_result_m(alu_result_m[0]), .write_data_m(write_data_m[0]),
        .write_reg_m(write_reg_m[0]), .stall_m(stall_m[0]), .reg_write_w(reg_write_w[0]),
        .mem_to_reg_w(mem_to_reg_w[0]), .read_data_w(read_data_w[0]), .alu_result_w(alu_result_w[0]),
        .write_reg_w(write_reg_w[0]), .misaligned_w(misaligned_w[0]));

    mem_stage #(.MEM_WORDS(256), .ACCESS_LATENCY(2)) u_l2 (
        .clk(clk), .reset(rst[1]), .reg_write_m(reg_write_m[1]), .mem_to_reg_m(mem_to_reg_m[1]),
        .mem_write_m(mem_write_m[1]), .alu_result_m(alu_result_m[1]), .write_data_m(write_data_m[1]),
        .write_reg_m(write_reg_m[1]), .stall_m(stall_m[1]), .reg_write_w(reg_write_w[1]),
        .mem_to_reg_w(mem_to_reg_w[1]), .read_data_w(read_data_w[1]), .alu_result_w(alu_result_w[1]),
        .write_reg_w(write_reg_w[1]), .misaligned_w(misaligned_w[1]));

    mem_stage #(.MEM_WORDS(256), .ACCESS_LATENCY(4)) u_l4 (
        .clk(clk), .reset(rst[2]), .reg_write_m(reg_write_m[2]), .mem_to_reg_m(mem_to_reg_m[2]),
        .mem_write_m(mem_write_m[2]), .alu_result_m(alu_result_m[2]), .write_data_m(write_data_m[2]),
        .write_reg_m(write_reg_m[2]), .stall_m(stall_m[2]), .reg_write_w(reg_write_w[2]),
        .mem_to_reg_w(mem_to_reg_w[2]), .read_data_w(read_data_w[2]), .alu_result_w(alu_result_w[2]),
        .write_reg_w(write_reg_w[2]), .misaligned_w(misaligned_w[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    function automatic logic [71:0] in_vec(input int d);
        return {reg_write_m[d], mem_to_reg_m[d], mem_write_m[d], alu_result_m[d],
                write_data_m[d], write_reg_m[d]};
    endfunction

    // Inputs must stay stable across any edge that follows a stalled edge.
    logic        prev_stall [3];
    logic [71:0] prev_in    [3];
    initial for (int d = 0; d < 3; d++) begin prev_stall[d] = 1'b0; prev_in[d] = '0; end
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (prev_stall[d] && !rst[d] && in_vec(d) !== prev_in[d]) begin
                $display("FAIL protocol d%0d: inputs changed while stalled", d);
                mismatched++;
            end
            prev_stall[d] <= stall_m[d];
            prev_in[d]    <= in_vec(d);
        end
    end

    task automatic drive_nop(input int d);
        reg_write_m[d] = 1'b0; mem_to_reg_m[d] = 1'b0; mem_write_m[d] = 1'b0;
        alu_result_m[d] = '0; write_data_m[d] = '0; write_reg_m[d] = '0;
    endtask

    task automatic do_op(input int d, input logic rw, input logic mtr, input logic mw,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wr,
                         input string name);
        exp_t e, g;
        int n, want_stall;
        logic [7:0] idx;
        logic mis;
        idx = addr[9:2];
        mis = (addr[1:0] != 2'b00);
        e.rw = rw; e.mtr = mtr; e.alu = addr; e.wr = wr;
        e.mis = (mtr | mw) & mis;
        e.rd  = (mtr && !mis) ? model[d][idx] : 32'h0;
        if (mw && !mis) model[d][idx] = wdata;
        sbq.push_back(e);
        want_stall = (mtr | mw) ? lat_of(d) - 1 : 0;

        @(negedge clk);
        reg_write_m[d] = rw; mem_to_reg_m[d] = mtr; mem_write_m[d] = mw;
        alu_result_m[d] = addr; write_data_m[d] = wdata; write_reg_m[d] = wr;
        #1;
        n = 0;
        while (stall_m[d] && n < 40) begin
            @(negedge clk);
            n++;
            compared++;
            if (reg_write_w[d] !== 1'b0 || mem_to_reg_w[d] !== 1'b0 || misaligned_w[d] !== 1'b0) begin
                $display("FAIL %s bubble d%0d: rw=%b mtr=%b mis=%b want 0 0 0", name, d,
                         reg_write_w[d], mem_to_reg_w[d], misaligned_w[d]);
                mismatched++;
            end
        end
        compared++;
        if (n != want_stall) begin
            $display("FAIL %s stall_cycles d%0d: got %0d want %0d", name, d, n, want_stall);
            mismatched++;
            if (n >= 40) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $fatal(1, "stall never released");
            end
        end
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        compared++;
        if (reg_write_w[d] !== g.rw || mem_to_reg_w[d] !== g.mtr || misaligned_w[d] !== g.mis) begin
            $display("FAIL %s ctrl d%0d: rw/mtr/mis got %b%b%b want %b%b%b", name, d,
                     reg_write_w[d], mem_to_reg_w[d], misaligned_w[d], g.rw, g.mtr, g.mis);
            mismatched++;
        end
        compared++;
        if (read_data_w[d] !== g.rd) begin
            $display("FAIL %s read_data d%0d: got %h want %h", name, d, read_data_w[d], g.rd);
            mismatched++;
        end
        compared++;
        if (alu_result_w[d] !== g.alu || write_reg_w[d] !== g.wr) begin
            $display("FAIL %s alu/wreg d%0d: got %h/%0d want %h/%0d", name, d,
                     alu_result_w[d], write_reg_w[d], g.alu, g.wr);
            mismatched++;
        end
        drive_nop(d);
    endtask

    task automatic check_zero(input int d, input string name);
        compared++;
        if (reg_write_w[d] !== 1'b0 || mem_to_reg_w[d] !== 1'b0 || read_data_w[d] !== 32'h0 ||
            alu_result_w[d] !== 32'h0 || write_reg_w[d] !== 5'h0 || misaligned_w[d] !== 1'b0 ||
            stall_m[d] !== 1'b0) begin
            $display("FAIL %s d%0d: w=%b%b %h %h %0d %b stall=%b want all 0", name, d,
                     reg_write_w[d], mem_to_reg_w[d], read_data_w[d], alu_result_w[d],
                     write_reg_w[d], misaligned_w[d], stall_m[d]);
            mismatched++;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin rst[d] = 1'b1; drive_nop(d); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_zero(d, "reset_state");
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    endtask

    task automatic test_nonmem();
        do_op(1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, "nonmem");
    endtask

    task automatic test_store_load();
        do_op(1, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, "store_10");
        do_op(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd8, "load_10");
    endtask

    task automatic test_latency4();
        do_op(2, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0000_55AA, 5'd0, "l4_store");
        do_op(2, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd3, "l4_load");
        @(posedge clk);
        #1;
        compared++;
        if (reg_write_w[2] !== 1'b0) begin
            $display("FAIL l4_single_result: reg_write_w got %b want 0", reg_write_w[2]);
            mismatched++;
        end
    endtask

    task automatic test_misaligned();
        do_op(1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 5'd0, "mis_prep");
        do_op(1, 1'b0, 1'b0, 1'b1, 32'h13, 32'h2222_2222, 5'd0, "mis_store");
        do_op(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd4, "mis_reload");
        do_op(1, 1'b1, 1'b1, 1'b0, 32'h12, 32'h0, 5'd9, "mis_load");
    endtask

    task automatic test_wrap();
        do_op(1, 1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 5'd0, "wrap_store");
        do_op(1, 1'b1, 1'b1, 1'b0, 32'h000, 32'h0, 5'd2, "wrap_load");
    endtask

    task automatic test_rmw();
        do_op(2, 1'b0, 1'b0, 1'b1, 32'h30, 32'h0000_0001, 5'd0, "rmw_prep");
        do_op(2, 1'b1, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 5'd7, "rmw_swap");
        do_op(2, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 5'd7, "rmw_check");
    endtask

    task automatic test_reset_midop();
        do_op(2, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 5'd0, "abort_prep");
        @(negedge clk);
        reg_write_m[2] = 1'b0; mem_to_reg_m[2] = 1'b0; mem_write_m[2] = 1'b1;
        alu_result_m[2] = 32'h20; write_data_m[2] = 32'hCAFE_F00D; write_reg_m[2] = 5'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        compared++;
        if (stall_m[2] !== 1'b0) begin
            $display("FAIL abort_stall_in_reset: got %b want 0", stall_m[2]);
            mismatched++;
        end
        @(negedge clk);
        rst[2] = 1'b0;
        drive_nop(2);
        #1;
        check_zero(2, "abort_after_reset");
        do_op(2, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd6, "abort_reload");
    endtask

    task automatic test_back_to_back();
        do_op(0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0F0F_0F0F, 5'd0, "b2b_st0");
        do_op(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd1, "b2b_ld0");
        do_op(0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h7777_0000, 5'd0, "b2b_st1");
        do_op(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd2, "b2b_ld1");
        do_op(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd31, "b2b_alu");
    endtask

    task automatic test_random();
        int order [8];
        for (int i = 0; i < 8; i++) begin
            do_op(2, 1'b0, 1'b0, 1'b1, 32'(32'h80 + 4 * i), $urandom, 5'd0, "rnd_store");
            order[i] = i;
        end
        for (int i = 0; i < 8; i++) begin
            int j, t;
            j = $urandom_range(7, 0);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 8; i++)
            do_op(2, 1'b1, 1'b1, 1'b0, 32'(32'h80 + 4 * order[i]), 32'h0, 5'(i + 10), "rnd_load");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin rst[d] = 1'b1; drive_nop(d); end
        test_reset();
        test_nonmem();
        test_store_load();
        test_latency4();
        test_misaligned();
        test_wrap();
        test_rmw();
        test_reset_midop();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
